// File: rtl/reg_mux_if.sv
// Data-path bundle for reg_mux: the sample stream going in and the selected
// tap coming back out. The producer side uses the master modport, the
// delay line itself uses the slave modport.
interface reg_mux_if #(
  parameter int Win = 16,
  parameter int SW  = 5
);
  logic signed [Win-1:0] din;
  logic                  ce;
  logic        [SW-1:0]  sel;
  logic signed [Win-1:0] dout;

  modport master (
    output din,
    output ce,
    output sel,
    input  dout
  );

  modport slave (
    input  din,
    input  ce,
    input  sel,
    output dout
  );
endinterface : reg_mux_if

// File: rtl/reg_mux.sv
// reg_mux: tapped delay line of Num_coef signed samples with a combinational
// tap selector. A sample enters tap 0 on every ce-qualified rising edge and
// ripples one tap deeper on each later qualified edge; the oldest sample
// falls off the end. Out-of-range selects read as zero. Samples are stored
// bit-exact, with no arithmetic applied.
module reg_mux #(
  parameter int Win      = 16,
  parameter int Num_coef = 17
) (
  input  logic      clk,
  input  logic      rst,
  reg_mux_if.slave  bus
);

  // Select width; a two-tap line still needs one select bit.
  localparam int SW = (Num_coef <= 2) ? 1 : $clog2(Num_coef);

  logic signed [Win-1:0] reg_array [Num_coef];
  logic signed [Win-1:0] dout_mux;

  // Delay line: shift all taps together on ce, clear everything on reset.
  // NOTE: every tap is cleared by the asynchronous reset because this is a
  // register file whose contents are observable right away on dout, not a
  // RAM; a RAM macro could not be cleared like this.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < Num_coef; k++) begin
        reg_array[k] <= '0;
      end
    end else if (bus.ce) begin
      // NOTE: non-blocking assignments make every tap load its neighbour's
      // pre-edge value, so the whole line moves by exactly one place.
      reg_array[0] <= bus.din;
      for (int k = 1; k < Num_coef; k++) begin
        reg_array[k] <= reg_array[k-1];
      end
    end
  end

  // Tap selector: pure mux on the current taps, zero when sel has no tap.
  // NOTE: dout_mux gets its default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    dout_mux = '0;
    for (int k = 0; k < Num_coef; k++) begin
      if (bus.sel == SW'(k)) begin
        dout_mux = reg_array[k];
      end
    end
  end

  assign bus.dout = dout_mux;

endmodule : reg_mux

// File: tb/tb_reg_mux.sv
// Self-checking bench for reg_mux. A queue-based reference model holds the
// expected tap contents: a qualified shift pushes the new sample on the
// front and drops the oldest from the back; reset refills it with zeros.
module tb_reg_mux;

  localparam int Win      = 16;
  localparam int Num_coef = 17;
  localparam int SW       = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  logic signed [Win-1:0] model_q [$];

  reg_mux_if #(.Win(Win), .SW(SW)) bus ();

  reg_mux #(.Win(Win), .Num_coef(Num_coef)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always terminates.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [Win-1:0] got,
                       input logic [Win-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    model_q.delete();
    repeat (Num_coef) model_q.push_back('0);
  endfunction

  function automatic void model_shift(input logic signed [Win-1:0] d);
    logic signed [Win-1:0] dropped;
    model_q.push_front(d);
    dropped = model_q.pop_back();
  endfunction

  function automatic logic signed [Win-1:0] model_tap(input int s);
    return (s < Num_coef) ? model_q[s] : '0;
  endfunction

  // One clock: drive at the falling edge, sample #1 after the rising edge,
  // then drop ce so later sweeps do not shift.
  task automatic shift_cycle(input logic ce_v, input logic [Win-1:0] d);
    @(negedge clk);
    bus.ce  = ce_v;
    bus.din = d;
    @(posedge clk);
    if (ce_v && rst) model_shift(d);
    #1;
    bus.ce = 1'b0;
  endtask

  task automatic read_tap(input int s, output logic [Win-1:0] v);
    bus.sel = SW'(s);
    #1;
    v = bus.dout;
  endtask

  // Compare every select value, including the out-of-range ones.
  task automatic sweep(input string tag);
    logic [Win-1:0] v;
    for (int s = 0; s < (1 << SW); s++) begin
      read_tap(s, v);
      check($sformatf("%s_sel%0d", tag, s), v, model_tap(s));
    end
  endtask

  initial begin
    logic [Win-1:0] v;
    int cnt;

    bus.ce  = 1'b0;
    bus.din = '0;
    bus.sel = '0;
    model_reset();

    // Reset from power-up: every select reads zero.
    #2 rst = 1'b0;
    sweep("por");
    @(negedge clk);
    rst = 1'b1;

    // Single shift.
    shift_cycle(1'b1, 16'd5);
    read_tap(0, v);  check("single_sel0", v, 16'd5);
    read_tap(1, v);  check("single_sel1", v, 16'd0);
    sweep("single");

    // Fill with 1..17, then one more.
    for (int i = 1; i <= Num_coef; i++) shift_cycle(1'b1, Win'(i));
    read_tap(0, v);  check("fill_sel0", v, 16'd17);
    read_tap(16, v); check("fill_sel16", v, 16'd1);
    sweep("fill");
    shift_cycle(1'b1, 16'd18);
    read_tap(0, v);  check("fill18_sel0", v, 16'd18);
    read_tap(16, v); check("fill18_sel16", v, 16'd2);
    sweep("fill18");

    // Hold: ce low for 20 edges while din keeps changing.
    for (int i = 0; i < 20; i++) shift_cycle(1'b0, Win'($urandom));
    read_tap(0, v);  check("hold_sel0", v, 16'd18);
    sweep("hold");

    // Sign extremes and out-of-range selects.
    shift_cycle(1'b1, 16'h8000);
    shift_cycle(1'b1, 16'h7fff);
    read_tap(0, v);  check("sign_sel0", v, 16'h7fff);
    read_tap(1, v);  check("sign_sel1", v, 16'h8000);
    read_tap(17, v); check("range_sel17", v, 16'd0);
    read_tap(31, v); check("range_sel31", v, 16'd0);
    sweep("sign");

    // Sparse enable: counter din, ce once every 17 cycles, sel sweeping.
    cnt = 0;
    for (int cyc = 0; cyc < Num_coef * 6; cyc++) begin
      @(negedge clk);
      bus.din = Win'(cnt);
      bus.ce  = (cyc % Num_coef) == 0;
      bus.sel = SW'(cyc % Num_coef);
      @(posedge clk);
      if (bus.ce) model_shift(Win'(cnt));
      #1;
      check($sformatf("sparse_c%0d", cyc), bus.dout, model_tap(cyc % Num_coef));
      cnt = (cnt + 1) % 26;
    end
    bus.ce = 1'b0;
    sweep("sparse");

    // Random traffic, including sel changing on shifting edges.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.din = Win'($urandom);
      bus.ce  = 1'($urandom_range(0, 1));
      bus.sel = SW'($urandom_range(0, 31));
      @(posedge clk);
      if (bus.ce) model_shift(bus.din);
      #1;
      check($sformatf("rand_%0d", i), bus.dout, model_tap(int'(bus.sel)));
    end
    bus.ce = 1'b0;

    // Mid-operation reset between edges, with ce held high while in reset.
    @(posedge clk);
    #2;
    bus.sel = SW'(0);
    bus.ce  = 1'b1;
    rst     = 1'b0;
    model_reset();
    #1;
    check("midrst_now_sel0", bus.dout, 16'd0);
    sweep("midrst");
    repeat (3) @(posedge clk);
    #1;
    sweep("rst_ce");
    @(negedge clk);
    bus.ce = 1'b0;
    rst    = 1'b1;
    shift_cycle(1'b1, 16'd7);
    read_tap(0, v);  check("post_rst_sel0", v, 16'd7);
    read_tap(1, v);  check("post_rst_sel1", v, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_reg_mux

// File: doc/reg_mux.md
REG_MUX -- requirements
Module: reg_mux

Interface
REQ-001 The module SHALL have parameter Win, default 16, meaning data width in bits (signed two's complement).
REQ-002 The module SHALL have parameter Num_coef, default 17, meaning number of taps in the delay line (minimum 2).
REQ-003 The module SHALL derive localparam SW = ceil(log2(Num_coef)) (5 for default), meaning select width; for Num_coef = 2 the value SHALL be 1.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port din, input, Win bits signed: sample to shift into the delay line.
REQ-007 Port ce, input, 1 bit: clock enable / sample-valid; high for one cycle shifts one sample.
REQ-008 Port sel, input, SW bits unsigned: tap index to present on dout.
REQ-009 Port dout, output, Win bits signed: selected tap value.

Function
REQ-010 The module SHALL hold an array reg_array[0..Num_coef-1] of Win-bit signed registers.
- ce=1 at rising clk: reg_array[0] <= din; reg_array[k] <= reg_array[k-1] for k = 1..Num_coef-1, all in the same edge.
- ce=0: all entries hold their value.
- reg_array[Num_coef-1] is discarded on shift; no wrap-around of data.
REQ-011 dout SHALL be a purely combinational multiplexer: dout = reg_array[sel], no register stage, zero cycles from sel to dout.
REQ-012 Latency: a sample presented on din with ce=1 at edge N SHALL appear on dout with sel=0 immediately after edge N, and with sel=k after k further ce-qualified shifts.
REQ-013 sel values >= Num_coef (for example 17..31 at the defaults) SHALL drive dout to 0.
REQ-014 sel changes concurrent with a shift SHALL address the post-edge array contents; there SHALL be no internal sel pipelining.
REQ-015 No arithmetic is performed: din bits SHALL be stored and returned unmodified, including the sign bit.
REQ-016 The module SHALL have no handshake output; ce is accepted unconditionally every cycle, including back-to-back cycles.

Reset
REQ-017 rst=0 SHALL clear every reg_array entry to 0 immediately, independent of clk, so dout = 0 for every sel during reset.
REQ-018 While rst=0, ce SHALL be ignored; the first shift SHALL occur at the first rising edge with rst=1 and ce=1.
REQ-019 Reset asserted mid-operation SHALL discard all stored samples; there SHALL be no partial retention.

Verification
REQ-020 Reset: load arbitrary data, pulse rst=0 between clock edges -> dout = 0 at once for sel = 0..16.
REQ-021 Single shift: din=5, ce=1 for one edge after reset -> sel=0 gives 5, sel=1..16 give 0.
REQ-022 Fill: ce=1 for 17 consecutive edges with din = 1..17 -> sel=k gives 17-k for k = 0..16; an 18th shift with din=18 gives 18 at sel=0 and 2 at sel=16.
REQ-023 Hold: ce=0 for 20 edges with changing din -> all taps unchanged for every sel.
REQ-024 Sparse enable: counter din 0..25 wrapping; ce pulsed once every 17 cycles; sel sweeps 0..16 -> dout at sel=0 equals the din captured at the last ce pulse; older taps hold the earlier captured values in order.
REQ-025 Sign and range: din = -32768 and 32767 shifted -> values returned bit-exact; sel = 17 and 31 -> dout = 0.
